// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared colours, pattern and FSM encodings for the video timing generator
package video_timing_pkg;

  localparam logic [23:0] WHITE   = 24'hFFFFFF;
  localparam logic [23:0] YELLOW  = 24'hFFFF00;
  localparam logic [23:0] CYAN    = 24'h00FFFF;
  localparam logic [23:0] GREEN   = 24'h00FF00;
  localparam logic [23:0] MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RED     = 24'hFF0000;
  localparam logic [23:0] BLUE    = 24'h0000FF;
  localparam logic [23:0] BLACK   = 24'h000000;

  typedef enum logic [1:0] {
    PAT_BAR   = 2'd0,
    PAT_GRID  = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_SOLID = 2'd3
  } pat_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return WHITE;
      3'd1:    return YELLOW;
      3'd2:    return CYAN;
      3'd3:    return GREEN;
      3'd4:    return MAGENTA;
      3'd5:    return RED;
      3'd6:    return BLUE;
      default: return BLACK;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_tx_timing_gen_if.sv
// rtl/hdmi_tx_timing_gen_if.sv - parallel RGB video bus towards the MS7210 transmitter
interface hdmi_tx_timing_gen_if;
  logic        video_hs;
  logic        video_vs;
  logic        video_de;
  logic [23:0] video_rgb;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic        frame_start;

  modport master (
    output video_hs, video_vs, video_de, video_rgb, pix_x, pix_y, frame_start
  );

  modport slave (
    input video_hs, video_vs, video_de, video_rgb, pix_x, pix_y, frame_start
  );
endinterface

// File: rtl/video_pattern_rom.sv
// rtl/video_pattern_rom.sv - combinational test pattern lookup from (pattern, x, y) to rgb
module video_pattern_rom
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = 1280
) (
  input  pat_e        pat,
  input  logic [11:0] x,
  input  logic [7:0]  y,
  output logic [23:0] rgb
);

  localparam logic [11:0] BAR_W = 12'(H_ACTIVE / 8);

  logic [2:0] bar;

  always_comb begin
    bar = 3'(x / BAR_W);
    rgb = BLACK;
    unique case (pat)
      PAT_BAR:   rgb = bar_colour(bar);
      PAT_GRID:  rgb = (x[4:0] == 5'd0 || y[4:0] == 5'd0) ? WHITE : BLACK;
      PAT_GRAD:  rgb = {x[7:0], y, x[7:0] + y};
      PAT_SOLID: rgb = WHITE;
      default:   rgb = BLACK;
    endcase
  end

endmodule

// File: rtl/hdmi_tx_timing_gen.sv
// rtl/hdmi_tx_timing_gen.sv - video timing FSM, counters and registered RGB outputs for the MS7210
module hdmi_tx_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        init_over,
  input  logic [1:0]                  pat_sel,
  hdmi_tx_timing_gen_if.master        vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic        init_m, init_s;
  state_e      state, state_nxt;
  logic [11:0] h_cnt, v_cnt;
  pat_e        pat_q, pat_cur;
  logic        running, origin, h_wrap, frame_wrap;
  logic        active, hs_region, vs_region;
  logic [23:0] rgb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_m <= 1'b0;
      init_s <= 1'b0;
    end else begin
      init_m <= init_over;
      init_s <= init_m;
    end
  end

  assign running    = (state != ST_IDLE);
  assign origin     = (h_cnt == 12'd0) && (v_cnt == 12'd0);
  assign h_wrap     = (h_cnt == H_LAST);
  assign frame_wrap = h_wrap && (v_cnt == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // DRAIN keeps counting so the frame in flight always finishes with whole sync pulses.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (init_s) state_nxt = ST_RUN;
      ST_RUN:   if (!init_s) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (init_s)          state_nxt = ST_RUN;
        else if (frame_wrap) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= 12'd0;
      v_cnt <= 12'd0;
    end else if (!running) begin
      h_cnt <= 12'd0;
      v_cnt <= 12'd0;
    end else begin
      h_cnt <= h_wrap ? 12'd0 : h_cnt + 12'd1;
      if (h_wrap) v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
    end
  end

  // The new selection is used from the origin pixel itself, so a frame never mixes patterns.
  assign pat_cur = origin ? pat_e'(pat_sel) : pat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pat_q <= PAT_BAR;
    else        pat_q <= pat_cur;
  end

  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_region = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_region = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

  video_pattern_rom #(.H_ACTIVE(H_ACTIVE)) u_rom (
    .pat (pat_cur),
    .x   (h_cnt),
    .y   (v_cnt[7:0]),
    .rgb (rgb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid.video_hs    <= ~SYNC_POL;
      vid.video_vs    <= ~SYNC_POL;
      vid.video_de    <= 1'b0;
      vid.video_rgb   <= 24'd0;
      vid.pix_x       <= 12'd0;
      vid.pix_y       <= 12'd0;
      vid.frame_start <= 1'b0;
    end else begin
      vid.video_hs    <= (running && hs_region) ? SYNC_POL : ~SYNC_POL;
      vid.video_vs    <= (running && vs_region) ? SYNC_POL : ~SYNC_POL;
      vid.video_de    <= running && active;
      vid.video_rgb   <= (running && active) ? rgb : 24'd0;
      vid.pix_x       <= (running && active) ? h_cnt : 12'd0;
      vid.pix_y       <= (running && active) ? v_cnt : 12'd0;
      vid.frame_start <= running && origin;
    end
  end

endmodule
